// File: rtl/pc_stack_fetch.sv
// pc_stack_fetch: program counter sequencer with a return-address stack.
//
// Selects one of NUM_PROGS start addresses on Start, then advances the PC
// every cycle in RUN, honouring (in priority order) Stall, Halt, Ret, Call,
// Jump. Call/Ret use a STACK_DEPTH-entry LIFO; overflow and underflow set a
// sticky StackErr and fall through to a plain increment.
//
// Ports:
//   Clk            sole clock, rising edge
//   Reset          synchronous active-high reset
//   Start          load selected program base and enter RUN (held while high)
//   ProgSel        program index; out-of-range selects entry 0
//   Stall          freeze all state this cycle (RUN only)
//   Jump           branch to Target
//   BranchAbsOrRel 0 = absolute, 1 = PC-relative Jump
//   Call           push PC+1, jump absolute to Target
//   Ret            pop return address into PC
//   Halt           enter HALT, PC unchanged
//   Target         branch/call target (two's complement offset when relative)
//   ProgCtr        program counter
//   Running        state is RUN
//   Done           state is HALT
//   StackErr       sticky overflow/underflow flag
//   Depth          stack occupancy
module pc_stack_fetch #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int NUM_PROGS   = 3,
    parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = {10'd0, 10'd128, 10'd256},
    localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int DEP_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] ProgSel,
    input  logic             Stall,
    input  logic             Jump,
    input  logic             BranchAbsOrRel,
    input  logic             Call,
    input  logic             Ret,
    input  logic             Halt,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic             StackErr,
    output logic [DEP_W-1:0] Depth
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEP_W-1:0] FULL = DEP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc, base_sel;
    logic [DEP_W-1:0]  depth_q, depth_d, top_w;
    logic              err_q, err_d, push;
    logic              running_q, done_q;
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];

    assign pc_inc = pc_q + PC_W'(1);
    assign top_w  = depth_q - DEP_W'(1);

    // Entry 0 sits in the most significant slice of PROG_BASE, so the table
    // reads left-to-right as program 0, 1, 2...
    always_comb begin
        base_sel = PROG_BASE[(NUM_PROGS-1)*PC_W +: PC_W];
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (ProgSel == SEL_W'(i))
                base_sel = PROG_BASE[(NUM_PROGS-1-i)*PC_W +: PC_W];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            depth_q   <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            depth_q   <= depth_d;
            err_q     <= err_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == HALT);
        end
    end

    // Stack storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge Clk) begin
        if (!Reset && push)
            stack_q[depth_q[IDX_W-1:0]] <= pc_inc;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
        if (Start) begin
            state_d = RUN;
            pc_d    = base_sel;
            depth_d = '0;
            err_d   = 1'b0;
        end else if (state_q == RUN && !Stall) begin
            if (Halt) begin
                state_d = HALT;
            end else if (Ret) begin
                if (depth_q != '0) begin
                    pc_d    = stack_q[top_w[IDX_W-1:0]];
                    depth_d = top_w;
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (Call) begin
                if (depth_q != FULL) begin
                    push    = 1'b1;
                    depth_d = depth_q + DEP_W'(1);
                    pc_d    = Target;
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (Jump) begin
                pc_d = BranchAbsOrRel ? pc_q + Target : Target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    assign ProgCtr  = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign StackErr = err_q;
    assign Depth    = depth_q;

endmodule

// File: tb/tb_pc_stack_fetch.sv
module tb_pc_stack_fetch;

    localparam int MASK = 1023;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

    logic       Clk = 1'b0;
    logic       Reset, Start, Stall, Jump, BranchAbsOrRel, Call, Ret, Halt;
    logic [1:0] ProgSel;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic       Running, Done, StackErr;
    logic [2:0] Depth;

    int checks = 0;
    int failures = 0;

    // Behavioural reference: plain integers and a queue as the stack.
    int m_pc = 0;
    int m_state = S_IDLE;
    int m_stk[$];
    bit m_err = 1'b0;
    int bases[3] = '{0, 128, 256};

    pc_stack_fetch dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .Stall(Stall), .Jump(Jump), .BranchAbsOrRel(BranchAbsOrRel),
        .Call(Call), .Ret(Ret), .Halt(Halt), .Target(Target),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
        .StackErr(StackErr), .Depth(Depth)
    );

    always #5 Clk = ~Clk;

    task automatic model_step();
        if (Reset) begin
            m_pc = 0; m_state = S_IDLE; m_stk.delete(); m_err = 0;
        end else if (Start) begin
            m_pc = (ProgSel < 3) ? bases[ProgSel] : bases[0];
            m_stk.delete(); m_err = 0; m_state = S_RUN;
        end else if (m_state == S_RUN && !Stall) begin
            if (Halt) m_state = S_HALT;
            else if (Ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_err = 1; m_pc = (m_pc + 1) & MASK; end
            end else if (Call) begin
                if (m_stk.size() < 4) begin
                    m_stk.push_back((m_pc + 1) & MASK); m_pc = int'(Target);
                end else begin m_err = 1; m_pc = (m_pc + 1) & MASK; end
            end else if (Jump)
                m_pc = BranchAbsOrRel ? (m_pc + int'(Target)) & MASK : int'(Target);
            else m_pc = (m_pc + 1) & MASK;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        Reset = 0; Start = 0; Stall = 0; Jump = 0; BranchAbsOrRel = 0;
        Call = 0; Ret = 0; Halt = 0; Target = '0; ProgSel = '0;
    endtask

    task automatic test_reset();
        clr(); Reset = 1; Start = 1; ProgSel = 2;
        tick(); tick();
        checks++; if (ProgCtr !== 10'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", ProgCtr); end
        checks++; if (Running !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL reset_state run=%b done=%b exp=0,0", Running, Done); end
        checks++; if (Depth !== 3'd0 || StackErr !== 1'b0) begin failures++; $display("FAIL reset_stack depth=%0d err=%b exp=0,0", Depth, StackErr); end
    endtask

    task automatic test_start();
        clr(); Start = 1; ProgSel = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ProgCtr !== 10'd128) begin failures++; $display("FAIL start_hold[%0d] got=%0d exp=128", i, ProgCtr); end
        end
        Start = 0;
        tick();
        checks++; if (ProgCtr !== 10'd129) begin failures++; $display("FAIL start_inc1 got=%0d exp=129", ProgCtr); end
        tick();
        checks++; if (ProgCtr !== 10'd130 || Running !== 1'b1) begin failures++; $display("FAIL start_inc2 pc=%0d run=%b exp=130,1", ProgCtr, Running); end
    endtask

    task automatic test_call_ret();
        clr(); Call = 1; Target = 10'd300;
        tick();
        checks++; if (ProgCtr !== 10'd300 || Depth !== 3'd1) begin failures++; $display("FAIL call pc=%0d depth=%0d exp=300,1", ProgCtr, Depth); end
        clr(); tick(); tick();
        checks++; if (ProgCtr !== 10'd302) begin failures++; $display("FAIL call_run got=%0d exp=302", ProgCtr); end
        Ret = 1; tick();
        checks++; if (ProgCtr !== 10'd131 || Depth !== 3'd0) begin failures++; $display("FAIL ret pc=%0d depth=%0d exp=131,0", ProgCtr, Depth); end
        clr();
    endtask

    task automatic test_overflow();
        int tg[4] = '{20, 40, 60, 80};
        int rp[5] = '{61, 41, 21, 132, 133};
        clr();
        for (int i = 0; i < 4; i++) begin
            Call = 1; Target = 10'(tg[i]); tick();
        end
        checks++; if (ProgCtr !== 10'd80 || Depth !== 3'd4 || StackErr !== 1'b0) begin failures++; $display("FAIL fill pc=%0d depth=%0d err=%b exp=80,4,0", ProgCtr, Depth, StackErr); end
        Target = 10'd500; tick();
        checks++; if (ProgCtr !== 10'd81 || Depth !== 3'd4 || StackErr !== 1'b1) begin failures++; $display("FAIL overflow pc=%0d depth=%0d err=%b exp=81,4,1", ProgCtr, Depth, StackErr); end
        clr(); Ret = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ProgCtr !== 10'(rp[i]) || Depth !== 3'(i < 4 ? 3 - i : 0) || StackErr !== 1'b1) begin
                failures++; $display("FAIL pop[%0d] pc=%0d depth=%0d err=%b exp_pc=%0d", i, ProgCtr, Depth, StackErr, rp[i]);
            end
        end
        clr();
    endtask

    task automatic test_jump_wrap();
        clr(); Jump = 1; Target = 10'd5; tick();
        checks++; if (ProgCtr !== 10'd5) begin failures++; $display("FAIL jump_abs got=%0d exp=5", ProgCtr); end
        BranchAbsOrRel = 1; Target = 10'h3FB; tick();
        checks++; if (ProgCtr !== 10'd0) begin failures++; $display("FAIL jump_rel_neg got=%0d exp=0", ProgCtr); end
        BranchAbsOrRel = 0; Target = 10'd1023; tick();
        clr(); tick();
        checks++; if (ProgCtr !== 10'd0) begin failures++; $display("FAIL inc_wrap got=%0d exp=0", ProgCtr); end
        Stall = 1; Jump = 1; Target = 10'd77; tick();
        checks++; if (ProgCtr !== 10'd0 || Running !== 1'b1) begin failures++; $display("FAIL stall_jump pc=%0d run=%b exp=0,1", ProgCtr, Running); end
        clr();
    endtask

    task automatic test_halt();
        clr(); Call = 1; Target = 10'd200; tick();
        clr(); Halt = 1; Ret = 1; tick();
        checks++; if (ProgCtr !== 10'd200 || Depth !== 3'd1 || Done !== 1'b1 || Running !== 1'b0) begin
            failures++; $display("FAIL halt_ret pc=%0d depth=%0d done=%b run=%b exp=200,1,1,0", ProgCtr, Depth, Done, Running);
        end
        clr(); Jump = 1; Target = 10'd9; tick(); tick();
        checks++; if (ProgCtr !== 10'd200 || Done !== 1'b1) begin failures++; $display("FAIL halt_jump pc=%0d done=%b exp=200,1", ProgCtr, Done); end
        clr(); Start = 1; ProgSel = 2; tick();
        checks++; if (ProgCtr !== 10'd256 || Running !== 1'b1 || Done !== 1'b0 || Depth !== 3'd0 || StackErr !== 1'b0) begin
            failures++; $display("FAIL restart pc=%0d run=%b done=%b depth=%0d err=%b exp=256,1,0,0,0", ProgCtr, Running, Done, Depth, StackErr);
        end
        clr();
    endtask

    task automatic test_reset_mid();
        clr(); Call = 1; Target = 10'd10; tick();
        Target = 10'd20; tick();
        checks++; if (Depth !== 3'd2) begin failures++; $display("FAIL pre_reset_depth got=%0d exp=2", Depth); end
        clr(); Reset = 1; Start = 1; ProgSel = 1; Call = 1; tick();
        checks++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || Depth !== 3'd0) begin failures++; $display("FAIL mid_reset pc=%0d run=%b depth=%0d exp=0,0,0", ProgCtr, Running, Depth); end
        clr();
        for (int i = 0; i < 4; i++) begin
            Jump = 1'(i); Call = 1'(i >> 1); Ret = 1; Target = 10'd33; tick();
        end
        checks++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || Depth !== 3'd0 || StackErr !== 1'b0) begin
            failures++; $display("FAIL idle_ignore pc=%0d run=%b depth=%0d err=%b exp=0,0,0,0", ProgCtr, Running, Depth, StackErr);
        end
        clr(); Start = 1; ProgSel = 3; tick();
        clr(); tick();
        checks++; if (ProgCtr !== 10'd1 || Running !== 1'b1) begin failures++; $display("FAIL sel_oob pc=%0d run=%b exp=1,1", ProgCtr, Running); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 600; n++) begin
            clr();
            Reset = ($urandom_range(0, 199) == 0);
            Start = ($urandom_range(0, 39) == 0);
            ProgSel = 2'($urandom_range(0, 3));
            Stall = ($urandom_range(0, 7) == 0);
            Halt  = ($urandom_range(0, 59) == 0);
            Ret   = ($urandom_range(0, 5) == 0);
            Call  = ($urandom_range(0, 4) == 0);
            Jump  = ($urandom_range(0, 4) == 0);
            BranchAbsOrRel = 1'($urandom_range(0, 1));
            Target = 10'($urandom);
            tick();
            checks++;
            if (ProgCtr !== 10'(m_pc) || Depth !== 3'(m_stk.size()) || StackErr !== m_err ||
                Running !== (m_state == S_RUN) || Done !== (m_state == S_HALT)) begin
                failures++;
                if (errs++ < 10)
                    $display("FAIL rand[%0d] pc=%0d/%0d depth=%0d/%0d err=%b/%b run=%b done=%b state_exp=%0d",
                             n, ProgCtr, m_pc, Depth, m_stk.size(), StackErr, m_err, Running, Done, m_state);
            end
        end
        clr();
    endtask

    initial begin
        clr();
        test_reset();
        test_start();
        test_call_ret();
        test_overflow();
        test_jump_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_stack_fetch.md
PC_STACK_FETCH -- requirements
Module: pc_stack_fetch

Interface
REQ-001 Parameter PC_W, default 10, sets the program counter and Target width in bits.
REQ-002 Parameter STACK_DEPTH, default 4, sets the number of return-address stack entries (>=1).
REQ-003 Parameter NUM_PROGS, default 3, sets the number of selectable program start addresses (>=1).
REQ-004 Parameter PROG_BASE, default {10'd0,10'd128,10'd256} (entry 0 = program 0), is a packed NUM_PROGS*PC_W start-address table.
REQ-005 Clk  input  1  sole clock; all state changes on posedge only.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Start  input  1  load selected program base; hold while asserted.
REQ-008 ProgSel  input  max(1,$clog2(NUM_PROGS))  program index sampled while Start=1.
REQ-009 Stall  input  1  freeze all state this cycle.
REQ-010 Jump  input  1  take branch to Target.
REQ-011 BranchAbsOrRel  input  1  0 = absolute (PC<=Target), 1 = relative (PC<=PC+Target).
REQ-012 Call  input  1  push return address, jump absolute to Target.
REQ-013 Ret  input  1  pop return address into PC.
REQ-014 Halt  input  1  end current program.
REQ-015 Target  input  PC_W  branch/call target; two's complement offset when relative.
REQ-016 ProgCtr  output  PC_W  program counter register.
REQ-017 Running  output  1  high in RUN state.
REQ-018 Done  output  1  high in HALT state.
REQ-019 StackErr  output  1  sticky overflow/underflow flag.
REQ-020 Depth  output  $clog2(STACK_DEPTH+1)  current stack occupancy.

Function
REQ-021 The block SHALL implement states IDLE, RUN, HALT; Running=(state==RUN), Done=(state==HALT), both registered.
REQ-022 Per-cycle priority SHALL be Reset > Start > Stall > Halt > Ret > Call > Jump > increment.
REQ-023 Start=1 in any state SHALL load ProgCtr<=PROG_BASE[ProgSel], clear stack (Depth=0), clear StackErr, enter RUN; ProgCtr holds base while Start stays high.
REQ-024 ProgSel>=NUM_PROGS with Start=1 SHALL load PROG_BASE[0].
REQ-025 In IDLE and HALT, Stall/Jump/Call/Ret/Halt SHALL be ignored and ProgCtr, stack, StackErr hold.
REQ-026 In RUN, Stall=1 SHALL hold ProgCtr, stack, Depth, state, StackErr regardless of other controls.
REQ-027 In RUN, Halt=1 SHALL enter HALT with ProgCtr unchanged.
REQ-028 In RUN, Ret with Depth>0 SHALL set ProgCtr<=top entry, Depth-1.
REQ-029 In RUN, Ret with Depth==0 SHALL set StackErr=1 and increment ProgCtr.
REQ-030 In RUN, Call with Depth<STACK_DEPTH SHALL push ProgCtr+1 (mod 2^PC_W), Depth+1, ProgCtr<=Target (BranchAbsOrRel ignored).
REQ-031 In RUN, Call with Depth==STACK_DEPTH SHALL set StackErr=1, leave stack unchanged, increment ProgCtr.
REQ-032 In RUN, Jump SHALL load Target (abs) or ProgCtr+Target (rel), result truncated to PC_W bits (wraps both directions).
REQ-033 In RUN with no control asserted, ProgCtr SHALL increment by 1, wrapping 2^PC_W-1 -> 0.
REQ-034 All updates SHALL take effect one cycle after the sampling edge; no combinational path from inputs to outputs.

Reset
REQ-035 Reset=1 SHALL set ProgCtr=0, state=IDLE, Depth=0, StackErr=0, Running=0, Done=0 on the next posedge, overriding Start and all controls, including mid-operation.

Verification
REQ-036 Reset, Start=1 ProgSel=1 for 3 cycles, release -> ProgCtr 128,128,128 then 129,130; Running=1.
REQ-037 RUN at PC=130: Call Target=300 -> PC=300, Depth=1; 2 idle cycles -> 302; Ret -> PC=131, Depth=0.
REQ-038 Defaults, RUN: 4 Calls then 5th Call at PC=p -> PC=p+1, Depth=4, StackErr=1; 5 Rets -> 4 pops then StackErr stays 1, PC increments.
REQ-039 PC=5, Jump rel Target=10'h3FB (-5) -> PC=0; PC=1023 increment -> 0; Stall+Jump together -> PC unchanged.
REQ-040 RUN: Halt+Ret same cycle -> HALT, Done=1, PC/Depth unchanged; Jump ignored in HALT; Start ProgSel=2 -> PC=256, RUN, Done=0.
REQ-041 Reset asserted with Start=1 and Depth=2 -> PC=0, IDLE, Depth=0; controls ignored until Start.
